// File: rtl/cpu_mem_ctrl.sv
// Arbitrated controller between the CPU fetch/data channels and one
// single-port synchronous memory. One access is in flight at a time:
// IDLE -> ACCESS -> (WAIT) -> RESP -> IDLE.
//
// Handshake: each requester holds req (and its address/data) high until it
// sees a one-cycle ack. Inputs are latched at grant and ignored afterwards,
// and requests are never sampled in RESP, so a requester may change or drop
// req in its ack cycle. An ack pulse always accompanies valid rdata (reads)
// or a completed write; rdata then holds until that channel's next read ack.
module cpu_mem_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t     state;
    logic       gnt_d;    // 1 = data channel owns the current transaction
    logic       last_d;   // 1 = most recent grant went to the data channel
    logic       lat_we;   // latched write flag (fetch always reads)
    logic [2:0] cnt;      // read-latency countdown
    logic       pick_d;   // arbitration result for this IDLE cycle

    assign state_dbg = state;

    // Arbitration: a lone requester wins; on a tie, round-robin or data-first
    always_comb begin
        pick_d = 1'b0;
        if (d_req && !if_req) begin
            pick_d = 1'b1;
        end else if (d_req && if_req) begin
            pick_d = (ARB_MODE == 1) ? 1'b1 : !last_d;
        end
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            last_d    <= 1'b1;   // first tie goes to fetch
            lat_we    <= 1'b0;
            cnt       <= 3'd0;
            if_ack    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        gnt_d     <= pick_d;
                        last_d    <= pick_d;
                        lat_we    <= pick_d & d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_d & d_we;
                        mem_addr  <= pick_d ? d_addr : if_addr;
                        mem_wdata <= pick_d ? d_wdata : '0;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        d_ack <= 1'b1;   // write completes in the memory cycle
                        state <= RESP;
                    end else begin
                        cnt   <= 3'(RD_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        // mem_rdata is valid in this cycle
                        if (gnt_d) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Bench for cpu_mem_ctrl: five instances share one clock/reset
// (RD_LAT 1..4 round-robin, plus RD_LAT 1 data-priority), each with its own
// memory model. A transaction-level reference model predicts grant order,
// ack cycles, memory cycles and read data.
module tb_cpu_mem_ctrl;

    localparam int NI = 5;
    localparam int DW = 16;

    function automatic int rdl(int k);
        return (k < 4) ? k + 1 : 1;
    endfunction

    function automatic int arbm(int k);
        return (k == 4) ? 1 : 0;
    endfunction

    function automatic logic [15:0] init_val(int a);
        if (a == 4) return 16'hA5A5;
        return 16'(a * 947) ^ 16'h5A5A;
    endfunction

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0]       if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
    logic [NI-1:0][15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [NI-1:0][15:0] mem_addr, mem_wdata, mem_rdata;
    logic [NI-1:0][1:0]  state_dbg;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g < 4) ? g + 1 : 1;
        localparam int A = (g == 4) ? 1 : 0;

        cpu_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_LAT(L), .ARB_MODE(A)) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
            .busy(busy[g]), .state_dbg(state_dbg[g])
        );

        // memory model: full address folded into 1024 words, RD_LAT pipeline
        logic [15:0] mem_arr [1024];
        logic [15:0] pipe_d [4];
        logic        pipe_v [4];
        logic [9:0]  idx;
        assign idx = mem_addr[g][9:0] ^ {4'b0, mem_addr[g][15:10]};

        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 1024; i++) mem_arr[i] <= init_val(i);
            end else if (mem_en[g] && mem_we[g]) begin
                mem_arr[idx] <= mem_wdata[g];
            end
            pipe_v[0] <= mem_en[g] && !mem_we[g];
            pipe_d[0] <= mem_arr[idx];
            for (int i = 1; i < 4; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
        assign mem_rdata[g] = pipe_v[L-1] ? pipe_d[L-1] : 16'hDEAD;
    end

    // reference model and scoreboard
    logic [15:0]   ref_mem [NI][1024];
    bit            last_d [NI];
    logic [15:0]   exp_if_rdata [NI];
    logic [15:0]   exp_d_rdata [NI];
    logic [DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            last_d[k] = 1'b1;
            exp_if_rdata[k] = '0;
            exp_d_rdata[k] = '0;
            for (int a = 0; a < 1024; a++) ref_mem[k][a] = init_val(a);
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = '0; if_addr = '0; d_req = '0; d_we = '0; d_addr = '0; d_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One scenario: fetch and/or data request raised together in an IDLE cycle
    task automatic run_txn(int k, bit use_f, bit use_d, logic [15:0] fa,
                           bit dwe, logic [15:0] da, logic [15:0] dwd);
        int  lat_f, lat_d, en1, en2, ack_f, ack_d, first_ack, last_ack;
        bit  both, f_first, chan_d, exp_en, exp_busy, exp_we;
        logic [15:0] exp_addr;
        lat_f = 2 + rdl(k);
        lat_d = dwe ? 2 : 2 + rdl(k);
        both  = use_f && use_d;
        if (both) f_first = (arbm(k) == 1) ? 1'b0 : last_d[k];
        else      f_first = use_f;
        en1 = 1; en2 = -1; ack_f = -1; ack_d = -1;
        if (f_first) begin
            ack_f = lat_f;
            if (use_d) begin en2 = ack_f + 2; ack_d = ack_f + 1 + lat_d; end
        end else begin
            ack_d = lat_d;
            if (use_f) begin en2 = ack_d + 2; ack_f = ack_d + 1 + lat_f; end
        end
        first_ack = f_first ? ack_f : ack_d;
        last_ack  = both ? ((ack_f > ack_d) ? ack_f : ack_d) : first_ack;
        last_d[k] = both ? f_first : use_d;
        // expected memory effects in grant order
        for (int g = 0; g < 2; g++) begin
            chan_d = (g == 0) ? !f_first : f_first;
            if (g == 1 && !both) break;
            if (!chan_d) exp_q.push_back(ref_mem[k][fa[9:0]]);
            else if (dwe) ref_mem[k][da[9:0]] = dwd;
            else exp_q.push_back(ref_mem[k][da[9:0]]);
        end

        @(posedge clk);
        #1;
        if_req[k] = use_f; if_addr[k] = fa;
        d_req[k] = use_d; d_we[k] = dwe; d_addr[k] = da; d_wdata[k] = dwd;

        for (int t = 1; t <= last_ack; t++) begin
            @(posedge clk);
            #1;
            exp_en = (t == en1) || (t == en2);
            checks++;
            if (mem_en[k] !== exp_en) begin
                errors++;
                $display("FAIL mem_en inst=%0d t=%0d got=%b exp=%b", k, t, mem_en[k], exp_en);
            end
            if (exp_en && mem_en[k]) begin
                chan_d   = (t == en1) ? !f_first : f_first;
                exp_we   = chan_d & dwe;
                exp_addr = chan_d ? da : fa;
                checks++;
                if ({mem_we[k], mem_addr[k]} !== {exp_we, exp_addr}) begin
                    errors++;
                    $display("FAIL mem_cmd inst=%0d t=%0d got we=%b addr=%h exp we=%b addr=%h",
                             k, t, mem_we[k], mem_addr[k], exp_we, exp_addr);
                end
                if (exp_we) begin
                    checks++;
                    if (mem_wdata[k] !== dwd) begin
                        errors++;
                        $display("FAIL mem_wdata inst=%0d t=%0d got=%h exp=%h", k, t, mem_wdata[k], dwd);
                    end
                end
            end
            exp_busy = !(both && t == first_ack + 1);
            checks++;
            if (busy[k] !== exp_busy) begin
                errors++;
                $display("FAIL busy inst=%0d t=%0d got=%b exp=%b", k, t, busy[k], exp_busy);
            end
            checks++;
            if (if_ack[k] !== (t == ack_f)) begin
                errors++;
                $display("FAIL if_ack inst=%0d t=%0d got=%b exp=%b", k, t, if_ack[k], (t == ack_f));
            end
            checks++;
            if (d_ack[k] !== (t == ack_d)) begin
                errors++;
                $display("FAIL d_ack inst=%0d t=%0d got=%b exp=%b", k, t, d_ack[k], (t == ack_d));
            end
            checks++;
            if (if_ack[k] && d_ack[k]) begin
                errors++;
                $display("FAIL dual_ack inst=%0d t=%0d got=11 exp=single", k, t);
            end
            if (t == ack_f) begin
                exp_if_rdata[k] = exp_q.pop_front();
                if_req[k] = 1'b0;
            end
            if (t == ack_d) begin
                if (!dwe) exp_d_rdata[k] = exp_q.pop_front();
                d_req[k] = 1'b0;
            end
            checks++;
            if (if_rdata[k] !== exp_if_rdata[k]) begin
                errors++;
                $display("FAIL if_rdata inst=%0d t=%0d got=%h exp=%h", k, t, if_rdata[k], exp_if_rdata[k]);
            end
            checks++;
            if (d_rdata[k] !== exp_d_rdata[k]) begin
                errors++;
                $display("FAIL d_rdata inst=%0d t=%0d got=%h exp=%h", k, t, d_rdata[k], exp_d_rdata[k]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({if_ack[k], if_rdata[k], d_ack[k], d_rdata[k], mem_en[k], mem_we[k],
                 mem_addr[k], mem_wdata[k], busy[k], state_dbg[k]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got nonzero exp=0", k);
            end
        end
    endtask

    task automatic test_single_fetch();
        run_txn(0, 1, 0, 16'h0004, 0, 16'h0000, 16'h0000);
        checks++;
        if (if_rdata[0] !== 16'hA5A5) begin
            errors++;
            $display("FAIL single_fetch_data got=%h exp=a5a5", if_rdata[0]);
        end
    endtask

    task automatic test_write_read();
        run_txn(2, 0, 1, 16'h0000, 1, 16'h0010, 16'h1234);
        run_txn(2, 0, 1, 16'h0000, 0, 16'h0010, 16'h0000);
        checks++;
        if (d_rdata[2] !== 16'h1234) begin
            errors++;
            $display("FAIL write_read_data got=%h exp=1234", d_rdata[2]);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        run_txn(0, 1, 1, 16'h0040, 0, 16'h0041, 16'h0000);   // fetch, data
        run_txn(0, 1, 1, 16'h0042, 0, 16'h0043, 16'h0000);   // fetch, data
        run_txn(4, 1, 1, 16'h0050, 0, 16'h0051, 16'h0000);   // data, fetch
        run_txn(4, 1, 1, 16'h0052, 1, 16'h0053, 16'hBEEF);   // data, fetch
    endtask

    task automatic test_input_stability();
        int acks, ack_t;
        logic [15:0] exp;
        exp = ref_mem[1][16'h0010];
        acks = 0; ack_t = -1;
        @(posedge clk);
        #1;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h0010; d_wdata[1] = 16'h0000;
        @(posedge clk);
        #1;
        checks++;
        if ({mem_en[1], mem_we[1], mem_addr[1]} !== {2'b10, 16'h0010}) begin
            errors++;
            $display("FAIL stable_access got en=%b we=%b addr=%h exp en=1 we=0 addr=0010",
                     mem_en[1], mem_we[1], mem_addr[1]);
        end
        d_addr[1] = 16'h00FF; d_req[1] = 1'b0; d_we[1] = 1'b1; d_wdata[1] = 16'($urandom);
        for (int t = 2; t <= 10; t++) begin
            @(posedge clk);
            #1;
            if (d_ack[1]) begin acks++; ack_t = t; end
            checks++;
            if (mem_en[1] !== 1'b0) begin
                errors++;
                $display("FAIL stable_extra_mem_en t=%0d got=1 exp=0", t);
            end
        end
        d_we[1] = 1'b0;
        checks++;
        if (acks !== 1 || ack_t !== 2 + rdl(1)) begin
            errors++;
            $display("FAIL stable_ack got count=%0d cycle=%0d exp count=1 cycle=%0d", acks, ack_t, 2 + rdl(1));
        end
        checks++;
        if (d_rdata[1] !== exp) begin
            errors++;
            $display("FAIL stable_rdata got=%h exp=%h", d_rdata[1], exp);
        end
        exp_d_rdata[1] = exp;
        last_d[1] = 1'b1;
        run_txn(1, 1, 0, 16'h00FF, 0, 16'h0000, 16'h0000);   // 0x00FF never written
    endtask

    task automatic test_reset_mid_wait();
        run_txn(3, 1, 0, 16'h0030, 0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        if_req[3] = 1'b1; if_addr[3] = 16'h0020;
        repeat (3) @(posedge clk);   // now in WAIT
        #1;
        rst = 1'b1;
        if_req[3] = 1'b0;
        #1;
        checks++;
        if ({if_ack[3], if_rdata[3], d_ack[3], d_rdata[3], mem_en[3], mem_we[3],
             mem_addr[3], mem_wdata[3], busy[3]} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait_outputs got nonzero exp=0");
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({if_ack[3], d_ack[3], busy[3]} !== 3'b000) begin
                errors++;
                $display("FAIL reset_no_ack t=%0d got=%b exp=000", t, {if_ack[3], d_ack[3], busy[3]});
            end
        end
        run_txn(3, 1, 0, 16'h0020, 0, 16'h0000, 16'h0000);
    endtask

    task automatic test_random_sweep();
        int mix;
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < ((k < 4) ? 50 : 20); n++) begin
                mix = $urandom_range(0, 2);
                run_txn(k, mix != 1, mix != 0, 16'($urandom_range(0, 1023)),
                        1'($urandom_range(0, 1)), 16'($urandom_range(0, 1023)), 16'($urandom));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_write_read();
        test_arbitration();
        test_input_stability();
        test_reset_mid_wait();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_ctrl.md
Name: cpu_mem_ctrl

Overview:
Parametrised memory controller between the CPU core and a single-port synchronous memory that holds both instructions and data. It replaces the separate instruction ROM handshake and data-RAM ports with one arbitrated bus. It serves two requester channels, instruction fetch (read-only) and data (read/write), with configurable widths, read latency and arbitration mode. It sits between cpu and the memory instance in top_cpu.

Parameters:
ADDR_W, 16, address width of both channels and memory
DATA_W, 16, data width of both channels and memory
RD_LAT, 1, memory read latency in cycles after mem_en; legal 1..4
ARB_MODE, 0, 0 = round-robin between channels, 1 = data channel fixed priority

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse, if_rdata valid in the same cycle
if_rdata  out  DATA_W  fetched word, held until next if_ack
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ack  out  1  one-cycle pulse: write done, or d_rdata valid
d_rdata  out  DATA_W  read word, held until next read d_ack
mem_en  out  1  memory enable, one cycle per access
mem_we  out  1  memory write enable, only with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en cycle
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; wait counter 0; last_grant = data channel, so the first tie goes to fetch.
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and rst.
- All outputs are registered.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: sample if_req/d_req.
  - If either is high, grant one channel.
  - Latch channel, addr, we (fetch forces we=0) and wdata.
  - Next state ACCESS. Otherwise stay in IDLE.
- Arbitration, both requests high:
  - ARB_MODE=0: grant the channel not in last_grant; last_grant updates on every grant.
  - ARB_MODE=1: data always wins.
- ACCESS, exactly one cycle: mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latch.
  - Write: next state RESP.
  - Read: load counter with RD_LAT, next state WAIT.
- WAIT: decrement counter each cycle. The cycle the counter reads 1 is the cycle in which mem_rdata is valid. Capture mem_rdata at the end of that cycle into the granted channel's rdata register, then go to RESP.
- RESP, one cycle: pulse the granted channel's ack; then IDLE. Requests are not sampled in RESP, so a requester may change req/addr in its ack cycle without a spurious grant.
- Latency, request first high in IDLE cycle N:
  - mem_en in cycle N+1.
  - Write ack in N+2.
  - Read ack in N+2+RD_LAT.
- Back-to-back: next grant no earlier than the cycle after RESP.
- Inputs changing after grant are ignored; the latched transaction completes.
- req deasserted mid-transaction: the transaction still completes and ack still pulses.
- The non-granted channel's rdata and ack are untouched during a transaction.
- Reset mid-transaction: immediate IDLE, mem_en=0, no ack issued, rdata registers cleared.
- mem_en/mem_we are 0 in every cycle except ACCESS.

Test Plan:
- Single fetch, RD_LAT=1: if_req=1, if_addr=0x0004, memory returns 0xA5A5 -> mem_en only in N+1; if_ack pulse in N+3 with if_rdata=0xA5A5; busy high N+1..N+3.
- Data write then read, RD_LAT=3: write 0x1234 to 0x0010, then read 0x0010 -> d_ack for the write in N+2 with mem_we=1 in N+1; read d_ack 5 cycles after its request with d_rdata=0x1234.
- Simultaneous requests, ARB_MODE=0, both held high for 4 transactions -> grant order fetch, data, fetch, data; ARB_MODE=1 -> data first, fetch only after d_req drops.
- Input stability: change d_addr to 0x00FF and deassert d_req the cycle after grant -> access still hits the original address; d_ack still pulses once.
- Reset during WAIT (RD_LAT=4, rst asserted mid-wait) -> outputs 0 immediately, no ack; a new fetch after release completes normally.
- Sweep RD_LAT=1..4 with 50 random mixed transactions against a memory model -> every ack at exactly the specified cycle with correct data; never two acks in one cycle.
